// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
//   state_t        : FSM states (IDLE, SHIFT)
//   IDLE_LEVEL_DEF : default line level while no word is being shifted
//   cnt_w()        : width of the per-word bit counter
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // Counter only ever holds WIDTH-1 down to 0.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake + serial bus for piso_serializer.
//   par_data/par_valid/par_ready : parallel word handshake
//   msb_first                    : bit order, sampled at load
//   ser_en                       : shift strobe
//   serial_out/ser_valid/ser_last/busy : serial line side
// master = producer/line driver side, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic             msb_first;
  logic             ser_en;
  logic             serial_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output par_data, par_valid, msb_first, ser_en,
    input  par_ready, serial_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  par_data, par_valid, msb_first, ser_en,
    output par_ready, serial_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_shift_core.sv
// WIDTH-bit shift register with synchronous clear, parallel load and
// directional shift. The output-end bit follows the shift direction.
//   clk     : clock
//   i_clr   : synchronous clear (highest priority)
//   i_load  : load i_data
//   i_data  : parallel word
//   i_shift : shift one position toward the output end, zero-fill
//   i_left  : 1 = output end is MSB (shift left), 0 = LSB (shift right)
//   o_bit   : current output-end bit
module piso_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  input  logic             i_left,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_sreg <= '0;
    else if (i_load)
      r_sreg <= i_data;
    else if (i_shift)
      r_sreg <= i_left ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
  end

  assign o_bit = i_left ? r_sreg[WIDTH-1] : r_sreg[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. Accepts a word over valid/ready, shifts
// it out one bit per ser_en strobe in a per-word bit order, flags the last
// bit, and can take the next word on the last strobe so words run gap-free.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : piso_serializer_if.slave (handshake + serial outputs)
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  piso_serializer_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("piso_serializer: WIDTH must be >= 2");
    end
  endgenerate

  state_t        r_state;
  logic [CW-1:0] r_bit_cnt;
  logic          r_order;

  logic w_in_shift;
  logic w_last_bit;
  logic w_ready;
  logic w_load;
  logic w_shift;
  logic w_core_bit;

  assign w_in_shift = (r_state == SHIFT);
  assign w_last_bit = (r_bit_cnt == '0);

  // While shifting, the next word can only be taken on the strobe that
  // consumes the last bit; that keeps back-to-back words gap-free.
  assign w_ready = !reset && (!w_in_shift || (bus.ser_en && w_last_bit));
  assign w_load  = bus.par_valid && w_ready;
  assign w_shift = w_in_shift && bus.ser_en && !w_last_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_order   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_order   <= bus.msb_first;
            r_bit_cnt <= CNT_MAX;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.ser_en) begin
            if (!w_last_bit) begin
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end else if (w_load) begin
              r_order   <= bus.msb_first;
              r_bit_cnt <= CNT_MAX;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load uses the incoming word; shift direction uses the latched order.
  piso_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .i_clr   (reset),
    .i_load  (w_load),
    .i_data  (bus.par_data),
    .i_shift (w_shift),
    .i_left  (r_order),
    .o_bit   (w_core_bit)
  );

  assign bus.par_ready  = w_ready;
  assign bus.serial_out = w_in_shift ? w_core_bit : IDLE_LEVEL;
  assign bus.ser_valid  = w_in_shift;
  assign bus.busy       = w_in_shift;
  assign bus.ser_last   = w_in_shift && w_last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [7:0] d, input logic msb);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.b    = msb ? d[7-i] : d[i];
      e.last = (i == 7);
      q.push_back(e);
    end
  endfunction

  // One cycle: check outputs at negedge against the scoreboard, then advance.
  task automatic step();
    @(negedge clk);
    if (bus.ser_valid === 1'b1) begin
      if (q.size() == 0) begin
        chki("extra_bit", q.size(), 1);
      end else begin
        chkb("bit", bus.serial_out, q[0].b);
        chkb("last", bus.ser_last, q[0].last);
        chkb("busy", bus.busy, 1'b1);
        chkb("ready_shift", bus.par_ready, !reset && bus.ser_en && q[0].last);
        if (bus.ser_en) void'(q.pop_front());
      end
    end else begin
      chkb("idle_out", bus.serial_out, 1'b0);
      chkb("idle_last", bus.ser_last, 1'b0);
      chkb("idle_busy", bus.busy, 1'b0);
      chkb("idle_ready", bus.par_ready, !reset);
      chki("valid_gap", q.size(), 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && bus.ser_valid !== 1'b1) break;
      step();
    end
    chki("drain_q", q.size(), 0);
    chkb("drain_valid", bus.ser_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset
    reset         = 1'b1;
    bus.par_data  = '0;
    bus.par_valid = 1'b0;
    bus.msb_first = 1'b0;
    bus.ser_en    = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    chkb("rst_ready", bus.par_ready, 1'b0);
    chkb("rst_out", bus.serial_out, 1'b0);
    reset = 1'b0;
    #1;
    chkb("rel_ready", bus.par_ready, 1'b1);

    // 2: LSB-first, ser_en constant
    bus.par_data = 8'hC5; bus.msb_first = 1'b0; bus.par_valid = 1'b1; bus.ser_en = 1'b1;
    step();
    push_word(8'hC5, 1'b0);
    bus.par_valid = 1'b0;
    drain();
    step();

    // 3: MSB-first, ser_en every 3rd cycle
    bus.par_data = 8'hC5; bus.msb_first = 1'b1; bus.par_valid = 1'b1; bus.ser_en = 1'b0;
    step();
    push_word(8'hC5, 1'b1);
    bus.par_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      bus.ser_en = (i % 3 == 2);
      step();
    end
    bus.ser_en = 1'b1;
    drain();

    // 4: back-to-back words, gap-free
    bus.par_data = 8'hC5; bus.msb_first = 1'b1; bus.par_valid = 1'b1; bus.ser_en = 1'b1;
    step();
    push_word(8'hC5, 1'b1);
    push_word(8'h3A, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && bus.ser_valid !== 1'b1) break;
      bus.par_data  = 8'h3A;
      bus.par_valid = (i <= 7);
      step();
    end
    chki("b2b_q", q.size(), 0);
    chkb("b2b_valid", bus.ser_valid, 1'b0);

    // 5: reset mid-word, par_valid ignored during reset
    bus.par_valid = 1'b0;
    step();
    bus.par_data = 8'hC5; bus.msb_first = 1'b1; bus.par_valid = 1'b1; bus.ser_en = 1'b1;
    step();
    push_word(8'hC5, 1'b1);
    bus.par_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1; bus.ser_en = 1'b0; bus.par_valid = 1'b1; bus.par_data = 8'hAA;
    step();
    q.delete();
    chkb("abort_valid", bus.ser_valid, 1'b0);
    chkb("abort_out", bus.serial_out, 1'b0);
    reset = 1'b0; bus.par_valid = 1'b0; bus.ser_en = 1'b1;
    step();
    bus.par_data = 8'hFF; bus.par_valid = 1'b1;
    step();
    push_word(8'hFF, 1'b1);
    bus.par_valid = 1'b0;
    drain();

    // 6: mid-word msb_first toggles and par_valid with bit_cnt != 0
    bus.par_data = 8'hC5; bus.msb_first = 1'b1; bus.par_valid = 1'b1; bus.ser_en = 1'b1;
    step();
    push_word(8'hC5, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && bus.ser_valid !== 1'b1) break;
      bus.msb_first = i[0];
      bus.par_data  = 8'hFF;
      bus.par_valid = (i < 7);
      step();
    end
    chki("mid_q", q.size(), 0);
    chkb("mid_valid", bus.ser_valid, 1'b0);
    bus.par_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
